// File: rtl/leb128_pkg.sv
// Shared types and helpers for the LEB128 encoder family.
package leb128_pkg;

    typedef enum logic {
        IDLE,
        EMIT
    } leb128_state_t;

    localparam int unsigned LEB128_CONT_BIT = 7;

    function automatic int unsigned leb128_max_bytes(input int unsigned width);
        return (width + 6) / 7;
    endfunction

endpackage

// File: rtl/leb128_byte_slice.sv
// One LEB128 encoding step: current byte, continuation flag and shifted remainder.
// Signed termination is only built when LEB128_SIGNED_EN is defined.
module leb128_byte_slice
    import leb128_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              sgn,
    output logic [7:0]        enc_byte,
    output logic              more,
    output logic [DATA_W-1:0] rem_next
);

    logic [DATA_W-1:0] lshr;
    logic [DATA_W-1:0] ashr;

    assign lshr     = rem >> 7;
    assign ashr     = $unsigned($signed(rem) >>> 7);
    assign rem_next = sgn ? ashr : lshr;

`ifdef LEB128_SIGNED_EN
    // Signed words stop once the remaining bits are pure sign extension of bit 6.
    always_comb begin
        if (sgn) begin
            more = !(((ashr == '0) && !rem[6]) || ((ashr == '1) && rem[6]));
        end else begin
            more = (lshr != '0);
        end
    end
`else
    assign more = (lshr != '0);
`endif

    always_comb begin
        enc_byte                        = '0;
        enc_byte[LEB128_CONT_BIT-1:0]   = rem[LEB128_CONT_BIT-1:0];
        enc_byte[LEB128_CONT_BIT]       = more;
    end

endmodule

// File: rtl/leb128_stream_enc.sv
// Streaming LEB128 encoder: one DATA_W-bit word in, one byte per cycle out.
// Define LEB128_SIGNED_EN to add the per-word in_signed (SLEB128) select.
module leb128_stream_enc
    import leb128_pkg::*;
#(
    parameter  int unsigned DATA_W    = 32,
    localparam int unsigned MAX_BYTES = leb128_max_bytes(DATA_W),
    localparam int unsigned LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef LEB128_SIGNED_EN
    input  logic              in_signed,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic [LEN_W-1:0]  out_len
);

    leb128_state_t     state, state_next;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] rem_next;
    logic              sgn;
    logic              sgn_in;
    logic [LEN_W-1:0]  idx;
    logic [7:0]        slice_byte;
    logic              more;
    logic              accept;
    logic              take;

`ifdef LEB128_SIGNED_EN
    assign sgn_in = in_signed;
`else
    assign sgn_in = 1'b0;
`endif

    leb128_byte_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .rem      (rem),
        .sgn      (sgn),
        .enc_byte (slice_byte),
        .more     (more),
        .rem_next (rem_next)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        out_len    = '0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = slice_byte;
                out_last  = !more;
                out_len   = idx;
                // Last byte leaving frees the slot in the same cycle for back-to-back words.
                in_ready  = out_ready && !more && !rst;
                if (out_ready && !more && !in_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready && more;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            sgn   <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rem <= in_data;
                sgn <= sgn_in;
                idx <= LEN_W'(1);
            end else if (take) begin
                rem <= rem_next;
                idx <= idx + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_bound: assert (idx <= LEN_W'(MAX_BYTES));
        end
    end

endmodule
